// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
//   Shared definitions for the instruction fetch stage: reset PC default,
//   register-bus width type, fetch FSM state encoding and the helper that
//   picks one 32-bit instruction out of a 64-bit memory beat.
// -----------------------------------------------------------------------------
package if_stage_pkg;

  localparam int unsigned REG_BUS_W = 64;

  typedef logic [REG_BUS_W-1:0] reg_bus_t;

  localparam reg_bus_t PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IF_ST_REQ   = 2'd0,  // request outstanding on the memory port
    IF_ST_WAIT  = 2'd1,  // request accepted, waiting for rvalid
    IF_ST_VALID = 2'd2   // instruction held for decode
  } if_state_e;

  // Memory returns an 8-byte aligned beat; pc[2] chooses the upper word.
  function automatic logic [31:0] select_word(input reg_bus_t rdata,
                                              input logic     upper);
    return upper ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction fetch stage. Owns the PC, issues one fetch at a time to the
//   instruction memory (req/ready, then rvalid), selects the 32-bit word and
//   hands inst/inst_addr to decode with valid/ready. Execute redirects have
//   priority in every state; a fetch already in flight when a redirect lands
//   is marked killed and its response is dropped.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   if_req         fetch request valid (high in REQ)
//   if_addr        fetch address, always the current pc
//   if_ready       memory accepts the request this cycle
//   if_rvalid      read data valid (only honoured in WAIT)
//   if_rdata       aligned 64-bit read data
//   redirect_ena   PC redirect strobe from execute
//   redirect_pc    redirect target (low two bits ignored)
//   inst_valid     inst/inst_addr valid to decode (high in VALID)
//   inst           fetched instruction
//   inst_addr      PC of inst
//   id_ready       decode consumes inst this cycle
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter reg_bus_t PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req,
  output reg_bus_t    if_addr,
  input  logic        if_ready,
  input  logic        if_rvalid,
  input  reg_bus_t    if_rdata,
  input  logic        redirect_ena,
  input  reg_bus_t    redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output reg_bus_t    inst_addr,
  input  logic        id_ready
);

  if_state_e state;
  if_state_e state_nxt;
  reg_bus_t  pc;
  logic      kill;

  logic accept;
  logic resp_take;
  logic unused_redirect_lsb;

  assign accept  = if_req & if_ready;
  assign if_addr = pc;

  // A response is consumed only when it belongs to the current pc: not
  // killed by an earlier redirect and not overtaken by one this cycle.
  assign resp_take = (state == IF_ST_WAIT) & if_rvalid & ~kill & ~redirect_ena;

  // Instructions are 4-byte aligned; the target's low bits are discarded.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IF_ST_REQ;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IF_ST_REQ: begin
        if (accept) state_nxt = IF_ST_WAIT;
      end
      IF_ST_WAIT: begin
        if (if_rvalid) state_nxt = (kill || redirect_ena) ? IF_ST_REQ : IF_ST_VALID;
      end
      IF_ST_VALID: begin
        if (redirect_ena || id_ready) state_nxt = IF_ST_REQ;
      end
      default: state_nxt = IF_ST_REQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    if_req     = (state == IF_ST_REQ);
    inst_valid = (state == IF_ST_VALID);
  end

  // ---------------------------------------------------------------------------
  // PC, kill flag and instruction holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_RESET;
      kill      <= 1'b0;
      inst      <= 32'h0;
      inst_addr <= '0;
    end else begin
      if (redirect_ena)   pc <= {redirect_pc[63:2], 2'b00};
      else if (resp_take) pc <= pc + 64'd4;

      // kill marks the single in-flight request as belonging to an old pc.
      case (state)
        IF_ST_REQ: begin
          if (accept) kill <= redirect_ena;
        end
        IF_ST_WAIT: begin
          if (if_rvalid)         kill <= 1'b0;
          else if (redirect_ena) kill <= 1'b1;
        end
        default: kill <= kill;
      endcase

      if (resp_take) begin
        inst      <= select_word(if_rdata, pc[2]);
        inst_addr <= pc;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//   Directed scenarios followed by a randomized run. A small memory responder
//   returns a deterministic function of the fetch address after a chosen
//   latency; the reference model only tracks "the next PC decode must see",
//   advancing by 4 on every transfer and jumping to the aligned target on
//   every redirect.
// -----------------------------------------------------------------------------
module tb_if_stage;
  import if_stage_pkg::*;

  localparam reg_bus_t PC_RST = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  reg_bus_t    if_addr;
  logic        if_ready;
  logic        if_rvalid;
  reg_bus_t    if_rdata;
  logic        redirect_ena;
  reg_bus_t    redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  reg_bus_t    inst_addr;
  logic        id_ready;

  always #5 clk = ~clk;

  if_stage #(.PC_RESET(PC_RST)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .redirect_ena (redirect_ena),
    .redirect_pc  (redirect_pc),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_addr    (inst_addr),
    .id_ready     (id_ready)
  );

  int       n_assert = 0;
  int       n_fail   = 0;

  // Memory responder state
  int       lat;
  bit       use_fixed;
  reg_bus_t fixed_data;
  bit       pend;
  int       cnt;
  reg_bus_t paddr;

  // Reference model state
  reg_bus_t exp_pc;
  int       n_xfer;

  function automatic logic [31:0] mem_word(input reg_bus_t a);
    logic [31:0] lo;
    lo = a[31:0];
    return lo ^ {lo[15:0], lo[31:16]} ^ 32'h1357_9BDF ^ a[63:32];
  endfunction

  function automatic reg_bus_t mem_line(input reg_bus_t a);
    return {mem_word({a[63:3], 3'b100}), mem_word({a[63:3], 3'b000})};
  endfunction

  task automatic check(input string tag, input reg_bus_t obs, input reg_bus_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: note any accept, advance the edge, then play the memory side.
  task automatic step();
    bit       acc;
    reg_bus_t a;
    acc = if_req && if_ready;
    a   = if_addr;
    if (acc) check("single_outstanding", 64'(pend), 64'd0);
    @(posedge clk);
    #1;
    if (if_rvalid) begin
      if_rvalid = 1'b0;
      pend      = 1'b0;
    end
    if (acc) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = a;
    end
    if (pend && !if_rvalid) begin
      cnt--;
      if (cnt == 0) begin
        if_rvalid = 1'b1;
        if_rdata  = use_fixed ? fixed_data : mem_line(paddr);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    if_ready     = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    redirect_ena = 1'b0;
    redirect_pc  = '0;
    id_ready     = 1'b0;
    lat          = 1;
    use_fixed    = 1'b1;
    fixed_data   = 64'h0000_0013_0010_0093;
    pend         = 1'b0;
    cnt          = 0;
    paddr        = '0;
    n_xfer       = 0;
    #1;
    step();
    step();

    // Reset state
    check("rst_if_req",     64'(if_req),     64'd1);
    check("rst_if_addr",    if_addr,         PC_RST);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst",       64'(inst),       64'd0);
    check("rst_inst_addr",  inst_addr,       64'd0);

    // Basic fetch, 1-cycle memory latency
    rst      = 1'b0;
    if_ready = 1'b1;
    check("f0_if_addr", if_addr, PC_RST);
    step();
    check("f0_wait_no_req", 64'(if_req), 64'd0);
    step();
    check("f0_valid",     64'(inst_valid), 64'd1);
    check("f0_inst",      64'(inst),       64'h0010_0093);
    check("f0_inst_addr", inst_addr,       PC_RST);

    // Decode stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid",     64'(inst_valid), 64'd1);
      check("stall_inst",      64'(inst),       64'h0010_0093);
      check("stall_inst_addr", inst_addr,       PC_RST);
      check("stall_no_req",    64'(if_req),     64'd0);
      check("stall_pc",        if_addr,         64'h8000_0004);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("f1_if_req",  64'(if_req),     64'd1);
    check("f1_if_addr", if_addr,         64'h8000_0004);
    check("f1_novalid", 64'(inst_valid), 64'd0);
    step();
    step();
    check("f1_inst",      64'(inst), 64'h0000_0013);
    check("f1_inst_addr", inst_addr, 64'h8000_0004);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("f2_if_addr", if_addr, 64'h8000_0008);

    // Redirect in the same cycle as an accept at 8000_0008
    fixed_data   = 64'h0000_0000_0000_DEAD;
    redirect_ena = 1'b1;
    redirect_pc  = 64'h8000_0203;
    step();
    redirect_ena = 1'b0;
    check("sc_if_addr", if_addr,     64'h8000_0200);
    check("sc_no_req",  64'(if_req), 64'd0);
    step();
    check("sc_dropped_valid", 64'(inst_valid), 64'd0);
    check("sc_dropped_inst",  64'(inst),       64'h0000_0013);
    check("sc_if_req",        64'(if_req),     64'd1);
    check("sc_next_addr",     if_addr,         64'h8000_0200);
    use_fixed = 1'b0;
    step();
    step();
    check("sc_valid",     64'(inst_valid), 64'd1);
    check("sc_inst_addr", inst_addr,       64'h8000_0200);
    check("sc_inst",      64'(inst),       64'(mem_word(64'h8000_0200)));
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;

    // Redirect while waiting; response arrives 3 cycles after accept
    use_fixed = 1'b1;
    lat       = 3;
    step();
    redirect_ena = 1'b1;
    redirect_pc  = 64'h8000_0100;
    step();
    redirect_ena = 1'b0;
    check("wt_if_addr", if_addr,     64'h8000_0100);
    check("wt_no_req",  64'(if_req), 64'd0);
    step();
    check("wt_rvalid_seen", 64'(if_rvalid), 64'd1);
    check("wt_novalid0", 64'(inst_valid), 64'd0);
    step();
    check("wt_novalid1", 64'(inst_valid), 64'd0);
    check("wt_if_req",   64'(if_req),     64'd1);
    check("wt_next",     if_addr,         64'h8000_0100);

    // Redirect during VALID with decode ready
    use_fixed = 1'b0;
    lat       = 1;
    step();
    step();
    check("vr_inst_addr", inst_addr, 64'h8000_0100);
    check("vr_inst",      64'(inst), 64'(mem_word(64'h8000_0100)));
    id_ready     = 1'b1;
    redirect_ena = 1'b1;
    redirect_pc  = 64'h8000_0400;
    step();
    redirect_ena = 1'b0;
    id_ready     = 1'b0;
    check("vr_novalid", 64'(inst_valid), 64'd0);
    check("vr_if_req",  64'(if_req),     64'd1);
    check("vr_if_addr", if_addr,         64'h8000_0400);
    step();
    step();
    check("vr_tgt_addr", inst_addr, 64'h8000_0400);
    check("vr_tgt_inst", 64'(inst), 64'(mem_word(64'h8000_0400)));

    // Reset while waiting, then a stray response
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    lat      = 3;
    step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    if_ready = 1'b0;
    check("mr_if_req",     64'(if_req),     64'd1);
    check("mr_if_addr",    if_addr,         PC_RST);
    check("mr_inst",       64'(inst),       64'd0);
    check("mr_inst_addr",  inst_addr,       64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stray_novalid", 64'(inst_valid), 64'd0);
      check("stray_if_req",  64'(if_req),     64'd1);
      check("stray_if_addr", if_addr,         PC_RST);
    end
    if_ready = 1'b1;
    lat      = 2;
    step();
    step();
    step();
    check("mr_fetch_valid", 64'(inst_valid), 64'd1);
    check("mr_fetch_addr",  inst_addr,       PC_RST);
    check("mr_fetch_inst",  64'(inst),       64'(mem_word(PC_RST)));

    // Randomized run against the instruction-stream model
    exp_pc = PC_RST;
    for (int i = 0; i < 3000; i++) begin
      reg_bus_t t;
      if_ready     = ($urandom_range(0, 3) != 0);
      id_ready     = ($urandom_range(0, 2) != 0);
      lat          = $urandom_range(1, 3);
      redirect_ena = ($urandom_range(0, 15) == 0);
      t            = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) t[63:5] = '1;
      redirect_pc  = t;
      if (if_req) check("rnd_req_addr", if_addr, exp_pc);
      if (redirect_ena) begin
        exp_pc = {t[63:2], 2'b00};
      end else if (inst_valid && id_ready) begin
        check("rnd_inst_addr", inst_addr, exp_pc);
        check("rnd_inst",      64'(inst), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        n_xfer++;
      end
      step();
    end
    redirect_ena = 1'b0;
    check("rnd_progress", 64'(n_xfer >= 100), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
